camera_cfg_sequencer: RTL and testbench
=======================================

Name: camera_cfg_sequencer

Overview:
- Sequences the camera register-init ROM (16-bit entries: {reg_addr[15:8], value[7:0]}, 7-bit address) and feeds each entry as one register write to the SCCB/I2C master.
- Sits between the config ROM and the SCCB master. Starts on request, interprets the delay and end-of-table markers, retries NACKed writes, and reports done/error to the top level, which gates the VGA capture path.

Parameters:
- DELAY_CYCLES, 250_000, clk cycles waited for a delay entry (10 ms at 25 MHz); counter width is $clog2(DELAY_CYCLES+1).
- MAX_RETRY, 3, NACKed attempts per entry before error (1..7).
- ADDR_W, 7, ROM address width.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse; begins (or restarts) the sequence
- rom_addr  out  ADDR_W  ROM address, registered
- rom_data  in  16  ROM data, valid one clk after rom_addr is sampled (synchronous ROM)
- sccb_ready  in  1  master idle, can accept a write
- sccb_start  out  1  one-cycle write request
- sccb_reg  out  8  register address, stable from sccb_start until sccb_done
- sccb_wdata  out  8  register value, same stability
- sccb_done  in  1  one-cycle pulse: transaction finished
- sccb_nack  in  1  qualified by sccb_done: slave NACKed
- busy  out  1  sequence in progress
- done  out  1  level; table completed without error
- err  out  1  level; aborted after MAX_RETRY NACKs
- err_addr  out  ADDR_W  ROM address of the failing entry

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; rom_addr=0, sccb_start=0, sccb_reg=0, sccb_wdata=0, busy=0, done=0, err=0, err_addr=0, retry count=0, delay counter=0. Reset overrides every state, including mid-transaction and mid-delay.
- States and transitions:
  - IDLE: on start, set rom_addr=0, clear done/err, set busy=1, go to FETCH.
  - FETCH: one cycle so the ROM registers data, then DECODE.
  - DECODE: evaluate rom_data.
    - 16'hFFFF: go to FINISH.
    - 16'hFFF0: load the delay counter with DELAY_CYCLES, go to DELAY.
    - Any other value: latch sccb_reg=rom_data[15:8], sccb_wdata=rom_data[7:0], retry=0, go to ISSUE.
  - ISSUE: wait for sccb_ready=1, then assert sccb_start for exactly one cycle and go to WAIT.
  - WAIT: hold until sccb_done.
    - sccb_nack=0: go to NEXT.
    - sccb_nack=1 and retry<MAX_RETRY-1: retry++, back to ISSUE.
    - Otherwise: err=1, err_addr=rom_addr, busy=0, go to ERROR.
  - DELAY: decrement each cycle; at 0 go to NEXT. Total dwell is DELAY_CYCLES cycles, ±1.
  - NEXT: if rom_addr == 2^ADDR_W-1, go to FINISH (no wrap). Otherwise rom_addr++ and go to FETCH.
  - FINISH: done=1, busy=0, go to IDLE.
  - ERROR: sticky; only start or reset leaves it. start restarts from address 0.
- Entry timing: 3 cycles of overhead per entry (FETCH, DECODE, NEXT) plus the SCCB time.
- start is ignored while busy=1.
- start in IDLE after a finished run clears done and reruns the full table.
- sccb_done outside WAIT is ignored.
- sccb_ready deasserting after sccb_start has been issued is irrelevant.
- rom_addr is held constant during ISSUE, WAIT and DELAY.
- A 16'hFFF0 entry never generates an SCCB write. An entry whose register address is 0xFF but data is not F0/FF is written normally.

Decomposition:
- Shared package cam_cfg_pkg holds: ROM_END=16'hFFFF, ROM_DELAY=16'hFFF0, the state enum typedef (IDLE, FETCH, DECODE, ISSUE, WAIT, DELAY, NEXT, FINISH, ERROR), and the entry struct typedef {logic [7:0] reg_addr; logic [7:0] value;}.
- One sub-module: cfg_delay_timer (load, count-down, expire pulse), reused by the SCCB master's power-up wait.
- The FSM stays flat in camera_cfg_sequencer.

Test Plan:
- Bench uses DELAY_CYCLES=8 and MAX_RETRY=3, with a model ROM holding 0:12_80, 1:FF_F0, 2:11_80, 3:FF_FF, and an SCCB model that asserts ready, then pulses done 5 cycles after start.
- Nominal run: start -> writes (12,80) then (11,80); the gap between the done of write 1 and the start of write 2 is ≥8 cycles; done=1 with busy=0 after address 3; exactly 2 sccb_start pulses.
- NACK recovery: nack on the first two attempts of address 2 -> three sccb_start pulses carrying (11,80), then done=1, err=0.
- NACK abort: nack on every attempt of address 0 -> exactly 3 pulses, then err=1, err_addr=0, done=0, busy=0; a later start reruns from rom_addr=0.
- No end marker: ROM returns 00_00 at every address -> 128 writes, done after address 127, rom_addr does not wrap.
- Reset mid-delay: rst_n=0 for one cycle during DELAY -> next cycle all outputs at reset values; start then resumes from address 0.
- start while busy: pulse start during WAIT -> ignored, sequence order unchanged.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// ---------------------------------------------------------------------------
// cam_cfg_pkg
// Shared definitions for the camera register-init path: ROM marker codes,
// sequencer state encoding and the layout of one ROM entry.
// ---------------------------------------------------------------------------
package cam_cfg_pkg;

  // Special ROM words. Any other word is a normal register write.
  localparam logic [15:0] ROM_END   = 16'hFFFF;
  localparam logic [15:0] ROM_DELAY = 16'hFFF0;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    ISSUE  = 4'd3,
    WAIT   = 4'd4,
    DELAY  = 4'd5,
    NEXT   = 4'd6,
    FINISH = 4'd7,
    ERROR  = 4'd8
  } cfg_state_t;

  // One ROM word: {register address, register value}.
  typedef struct packed {
    logic [7:0] reg_addr;
    logic [7:0] value;
  } entry_t;

endpackage

// File: rtl/cfg_delay_timer.sv
// ---------------------------------------------------------------------------
// cfg_delay_timer
// Loadable count-down timer. A load starts a wait of load_val cycles; expire
// is high during the last cycle of that wait (one cycle), after which the
// timer idles at zero until the next load. A load_val of 0 or 1 expires on
// the first cycle after the load.
//
// Ports:
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   load      in   start a new wait (wins over counting)
//   load_val  in   wait length in cycles
//   expire    out  last cycle of the wait
// ---------------------------------------------------------------------------
module cfg_delay_timer #(
  parameter int W = 18
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] count;
  logic         running;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (count <= W'(1)) begin
        count   <= '0;
        running <= 1'b0;
      end else begin
        count <= count - W'(1);
      end
    end
  end

  assign expire = running && !load && (count <= W'(1));

endmodule

// File: rtl/camera_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// camera_cfg_sequencer
// Walks the camera init ROM and turns each entry into one SCCB register
// write. Handles the delay marker (ROM_DELAY), the end marker (ROM_END),
// retries NACKed writes and reports done/err to the top level.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start                 pulse: begin/restart the table (ignored while busy)
//   rom_addr / rom_data   synchronous ROM interface (data one clk after addr)
//   sccb_ready            master can accept a write
//   sccb_start            one-cycle write request
//   sccb_reg, sccb_wdata  write payload, held until sccb_done
//   sccb_done, sccb_nack  transaction finished / slave NACKed
//   busy, done, err       status levels
//   err_addr              ROM address of the entry that exhausted its retries
// ---------------------------------------------------------------------------
module camera_cfg_sequencer
  import cam_cfg_pkg::*;
#(
  parameter int DELAY_CYCLES = 250_000,
  parameter int MAX_RETRY    = 3,
  parameter int ADDR_W       = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  input  logic              sccb_ready,
  output logic              sccb_start,
  output logic [7:0]        sccb_reg,
  output logic [7:0]        sccb_wdata,
  input  logic              sccb_done,
  input  logic              sccb_nack,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] err_addr
);

  localparam int CNT_W = $clog2(DELAY_CYCLES + 1);

  cfg_state_t state;
  logic [2:0] retry;
  entry_t     entry;
  logic       tmr_load;
  logic       tmr_expire;

  assign entry    = entry_t'(rom_data);
  assign tmr_load = (state == DECODE) && (rom_data == ROM_DELAY);

  cfg_delay_timer #(.W(CNT_W)) u_delay (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (CNT_W'(DELAY_CYCLES)),
    .expire   (tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      rom_addr   <= '0;
      sccb_start <= 1'b0;
      sccb_reg   <= '0;
      sccb_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_addr   <= '0;
      retry      <= '0;
    end else begin
      // Request is a single-cycle strobe; only ISSUE raises it.
      sccb_start <= 1'b0;

      case (state)
        // ERROR is sticky: only a new start (or reset) leaves it.
        IDLE, ERROR: begin
          if (start) begin
            rom_addr <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b1;
            state    <= FETCH;
          end
        end

        // ROM registers rom_addr this cycle; rom_data is valid in DECODE.
        FETCH: state <= DECODE;

        DECODE: begin
          if (rom_data == ROM_END) begin
            state <= FINISH;
          end else if (rom_data == ROM_DELAY) begin
            state <= DELAY;
          end else begin
            sccb_reg   <= entry.reg_addr;
            sccb_wdata <= entry.value;
            retry      <= '0;
            state      <= ISSUE;
          end
        end

        ISSUE: begin
          if (sccb_ready) begin
            sccb_start <= 1'b1;
            state      <= WAIT;
          end
        end

        WAIT: begin
          if (sccb_done) begin
            if (!sccb_nack) begin
              state <= NEXT;
            end else if (retry < 3'(MAX_RETRY - 1)) begin
              retry <= retry + 3'd1;
              state <= ISSUE;
            end else begin
              err      <= 1'b1;
              err_addr <= rom_addr;
              busy     <= 1'b0;
              state    <= ERROR;
            end
          end
        end

        DELAY: begin
          if (tmr_expire) state <= NEXT;
        end

        // Last ROM address terminates the table instead of wrapping.
        NEXT: begin
          if (rom_addr == {ADDR_W{1'b1}}) begin
            state <= FINISH;
          end else begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state    <= FETCH;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_camera_cfg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_camera_cfg_sequencer
// Directed bench: model sync ROM + SCCB master (ready when idle, done 5
// cycles after start, optional NACKs on one register address).
// ---------------------------------------------------------------------------
module tb_camera_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sccb_ready;
  logic        sccb_start;
  logic [7:0]  sccb_reg;
  logic [7:0]  sccb_wdata;
  logic        sccb_done;
  logic        sccb_nack;
  logic        busy;
  logic        done;
  logic        err;
  logic [6:0]  err_addr;

  camera_cfg_sequencer #(
    .DELAY_CYCLES (8),
    .MAX_RETRY    (3),
    .ADDR_W       (7)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .sccb_ready (sccb_ready),
    .sccb_start (sccb_start),
    .sccb_reg   (sccb_reg),
    .sccb_wdata (sccb_wdata),
    .sccb_done  (sccb_done),
    .sccb_nack  (sccb_nack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_addr   (err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous ROM model.
  logic [15:0] rom [128];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // SCCB model state and transaction log.
  logic [15:0] wr_log [$];
  int          start_cyc [$];
  int          done_cyc [$];
  int          nack_left = 0;
  logic [7:0]  nack_reg  = 8'h00;

  initial begin
    int wait_cnt;
    bit pending;
    pending    = 0;
    wait_cnt   = 0;
    sccb_ready = 1'b1;
    sccb_done  = 1'b0;
    sccb_nack  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      sccb_done = 1'b0;
      sccb_nack = 1'b0;
      if (!rst_n) begin
        pending    = 0;
        sccb_ready = 1'b1;
      end else if (pending) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          sccb_done = 1'b1;
          if (nack_left > 0 && sccb_reg == nack_reg) begin
            sccb_nack = 1'b1;
            nack_left--;
          end
          done_cyc.push_back(cyc);
          pending    = 0;
          sccb_ready = 1'b1;
        end
      end else if (sccb_start) begin
        wr_log.push_back({sccb_reg, sccb_wdata});
        start_cyc.push_back(cyc);
        pending    = 1;
        wait_cnt   = 5;
        sccb_ready = 1'b0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : 16'hDEAD;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_log.delete();
    start_cyc.delete();
    done_cyc.delete();
  endtask

  task automatic load_default_rom();
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    rom[2] = 16'h1180;
    rom[3] = 16'hFFFF;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic run_to_end(input string tag, input int budget);
    int n = 0;
    while (!(done || err) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished_in_budget"}, 32'(done || err), 32'd1);
  endtask

  task automatic wait_done_pulses(input string tag, input int k, input int budget);
    int n = 0;
    while (done_cyc.size() < k && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_sccb_done_seen"}, 32'(done_cyc.size() >= k), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rom_addr"},   32'(rom_addr),   32'h0);
    check({tag, "_sccb_start"}, 32'(sccb_start), 32'h0);
    check({tag, "_sccb_reg"},   32'(sccb_reg),   32'h0);
    check({tag, "_sccb_wdata"}, 32'(sccb_wdata), 32'h0);
    check({tag, "_busy"},       32'(busy),       32'h0);
    check({tag, "_done"},       32'(done),       32'h0);
    check({tag, "_err"},        32'(err),        32'h0);
    check({tag, "_err_addr"},   32'(err_addr),   32'h0);
  endtask

  initial begin
    int gap;
    rst_n = 1'b0;
    start = 1'b0;
    load_default_rom();

    // Reset state.
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    tick(2);

    // Nominal run: two writes, a delay between them, then done.
    clear_log();
    pulse_start();
    check("nom_busy_after_start", 32'(busy), 32'd1);
    check("nom_rom_addr_first", 32'(rom_addr), 32'd0);
    run_to_end("nom", 400);
    check("nom_starts", 32'(wr_log.size()), 32'd2);
    check("nom_w0", 32'(log_at(0)), 32'h1280);
    check("nom_w1", 32'(log_at(1)), 32'h1180);
    gap = (start_cyc.size() > 1 && done_cyc.size() > 0) ? start_cyc[1] - done_cyc[0] : 0;
    // Expected gap is 16 (NEXT, FETCH, DECODE, 8 delay, NEXT, FETCH, DECODE, ISSUE + sampling).
    check("nom_gap_ge_delay", 32'(gap >= 8), 32'd1);
    check("nom_gap_bounded", 32'(gap <= 24), 32'd1);
    check("nom_done", 32'(done), 32'd1);
    check("nom_busy", 32'(busy), 32'd0);
    check("nom_err", 32'(err), 32'd0);
    check("nom_end_addr", 32'(rom_addr), 32'd3);

    // NACK recovery: first two attempts at reg 0x11 NACKed.
    clear_log();
    nack_reg  = 8'h11;
    nack_left = 2;
    pulse_start();
    run_to_end("rec", 400);
    check("rec_starts", 32'(wr_log.size()), 32'd4);
    check("rec_w1", 32'(log_at(1)), 32'h1180);
    check("rec_w2", 32'(log_at(2)), 32'h1180);
    check("rec_w3", 32'(log_at(3)), 32'h1180);
    check("rec_done", 32'(done), 32'd1);
    check("rec_err", 32'(err), 32'd0);

    // NACK abort at address 0.
    clear_log();
    nack_reg  = 8'h12;
    nack_left = 1000;
    pulse_start();
    run_to_end("ab0", 400);
    tick(10);
    check("ab0_starts", 32'(wr_log.size()), 32'd3);
    check("ab0_err", 32'(err), 32'd1);
    check("ab0_err_addr", 32'(err_addr), 32'd0);
    check("ab0_done", 32'(done), 32'd0);
    check("ab0_busy", 32'(busy), 32'd0);

    // Restart from ERROR reruns from address 0.
    clear_log();
    nack_left = 0;
    pulse_start();
    check("ab0_restart_busy", 32'(busy), 32'd1);
    check("ab0_restart_err_clr", 32'(err), 32'd0);
    check("ab0_restart_addr", 32'(rom_addr), 32'd0);
    run_to_end("ab0_rerun", 400);
    check("ab0_rerun_starts", 32'(wr_log.size()), 32'd2);
    check("ab0_rerun_w0", 32'(log_at(0)), 32'h1280);
    check("ab0_rerun_done", 32'(done), 32'd1);

    // NACK abort at address 2 reports that address.
    clear_log();
    nack_reg  = 8'h11;
    nack_left = 1000;
    pulse_start();
    run_to_end("ab2", 400);
    check("ab2_starts", 32'(wr_log.size()), 32'd4);
    check("ab2_err", 32'(err), 32'd1);
    check("ab2_err_addr", 32'(err_addr), 32'd2);
    check("ab2_done", 32'(done), 32'd0);
    nack_left = 0;

    // start while busy (during WAIT of the first write) is ignored.
    clear_log();
    pulse_start();
    begin
      int n = 0;
      while (wr_log.size() < 1 && n < 100) begin
        @(negedge clk);
        n++;
      end
    end
    check("bsy_first_issued", 32'(wr_log.size()), 32'd1);
    pulse_start();
    run_to_end("bsy", 400);
    check("bsy_starts", 32'(wr_log.size()), 32'd2);
    check("bsy_w0", 32'(log_at(0)), 32'h1280);
    check("bsy_w1", 32'(log_at(1)), 32'h1180);
    check("bsy_done", 32'(done), 32'd1);

    // Reset in the middle of the delay entry.
    clear_log();
    pulse_start();
    wait_done_pulses("mid", 1, 100);
    tick(6);
    check("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    tick(20);
    check("mid_no_more_writes", 32'(wr_log.size()), 32'd1);
    check("mid_idle_busy", 32'(busy), 32'd0);
    clear_log();
    pulse_start();
    run_to_end("mid_rerun", 400);
    check("mid_rerun_starts", 32'(wr_log.size()), 32'd2);
    check("mid_rerun_w0", 32'(log_at(0)), 32'h1280);
    check("mid_rerun_done", 32'(done), 32'd1);

    // No end marker: every address written, no wrap past 127.
    for (int i = 0; i < 128; i++) rom[i] = 16'h0000;
    clear_log();
    pulse_start();
    run_to_end("noend", 5000);
    check("noend_starts", 32'(wr_log.size()), 32'd128);
    check("noend_done", 32'(done), 32'd1);
    check("noend_err", 32'(err), 32'd0);
    check("noend_last_addr", 32'(rom_addr), 32'd127);
    tick(10);
    check("noend_no_wrap_addr", 32'(rom_addr), 32'd127);
    check("noend_no_extra", 32'(wr_log.size()), 32'd128);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
